mem_arbiter: RTL and testbench

Two-master arbiter in front of the shared memory request port. Master 0 is the 68040 bus interface; master 1 is the second bus master (DMA/video fetch). Both use the same request/write/read stream protocol as the downstream memory controller. The block grants one master per burst, forwards its request, routes write and read beats, and releases the grant only after the last beat of the burst.

---
 rtl/mem_pkg.sv | 14 +
 rtl/arb_pick2.sv | 10 +
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, FSM state encoding and request field layout for mem_arbiter.
package mem_pkg;
   localparam int LW_DEF = 3;
   localparam int MW = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DATA = 2'd2} state_t;
   typedef struct packed {
      logic [MW-1:0] mask;
      logic [AW-1:0] addr;
      logic          we;
      logic          wrap;
   } req_t;
endpackage

// File: rtl/arb_pick2.sv
// arb_pick2: combinational two-way picker; a tie goes to m0, or to the master
// not granted last when round-robin is enabled.
module arb_pick2 (
   input  logic [1:0] i_valid,
   input  logic       i_last,
   input  logic       i_rr_en,
   output logic       o_win
);
   assign o_win = (&i_valid) ? (i_rr_en & ~i_last) : i_valid[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master burst arbiter in front of the shared memory request port.
// Define ARB_RR_EN for round-robin tie breaking; default is fixed priority (m0 wins).
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int LW = LW_DEF
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          m0_req_valid,
   output logic          m0_req_ready,
   input  logic [LW-1:0] m0_req_len,
   input  logic [MW-1:0] m0_req_mask,
   input  logic [AW-1:0] m0_req_addr,
   input  logic          m0_req_we,
   input  logic          m0_req_wrap,
   input  logic          m0_write_valid,
   input  logic [DW-1:0] m0_write_data,
   output logic          m0_read_valid,
   output logic [DW-1:0] m0_read_data,
   input  logic          m0_read_ack,
   input  logic          m1_req_valid,
   output logic          m1_req_ready,
   input  logic [LW-1:0] m1_req_len,
   input  logic [MW-1:0] m1_req_mask,
   input  logic [AW-1:0] m1_req_addr,
   input  logic          m1_req_we,
   input  logic          m1_req_wrap,
   input  logic          m1_write_valid,
   input  logic [DW-1:0] m1_write_data,
   output logic          m1_read_valid,
   output logic [DW-1:0] m1_read_data,
   input  logic          m1_read_ack,
   output logic          s_req_valid,
   input  logic          s_req_ready,
   output logic [LW-1:0] s_req_len,
   output logic [MW-1:0] s_req_mask,
   output logic [AW-1:0] s_req_addr,
   output logic          s_req_we,
   output logic          s_req_wrap,
   output logic          s_write_valid,
   output logic [DW-1:0] s_write_data,
   input  logic          s_read_valid,
   input  logic [DW-1:0] s_read_data,
   output logic          s_read_ack,
   output logic          owner
);
   state_t        r_state, w_state_nxt;
   logic          r_owner, r_we;
   logic [LW-1:0] r_beats;
   logic          w_any, w_win, w_last, w_rr_en, w_acc, w_beat, w_rd, w_wr;
   logic          w_valid, w_wv, w_ack;
   logic [LW-1:0] w_len;
   logic [DW-1:0] w_wd;
   req_t          w_req;

   assign w_any = m0_req_valid | m1_req_valid;

   arb_pick2 u_pick (
      .i_valid({m1_req_valid, m0_req_valid}),
      .i_last (w_last),
      .i_rr_en(w_rr_en),
      .o_win  (w_win)
   );

`ifdef ARB_RR_EN
   logic r_last;
   always_ff @(posedge clk_i)
      if (rst_i) r_last <= 1'b1;
      else if (r_state == IDLE && w_any) r_last <= w_win;
   assign w_rr_en = 1'b1;
   assign w_last  = r_last;
`else
   assign w_rr_en = 1'b0;
   assign w_last  = 1'b1;
`endif

   // Owner-side mux of every master field; all forwarding is combinational.
   assign w_req   = r_owner ? req_t'({m1_req_mask, m1_req_addr, m1_req_we, m1_req_wrap})
                            : req_t'({m0_req_mask, m0_req_addr, m0_req_we, m0_req_wrap});
   assign w_len   = r_owner ? m1_req_len     : m0_req_len;
   assign w_valid = r_owner ? m1_req_valid   : m0_req_valid;
   assign w_wv    = r_owner ? m1_write_valid : m0_write_valid;
   assign w_wd    = r_owner ? m1_write_data  : m0_write_data;
   assign w_ack   = r_owner ? m1_read_ack    : m0_read_ack;

   assign w_rd = (r_state == DATA) & ~r_we;
   assign w_wr = (r_state == DATA) & r_we;

   assign s_req_valid   = (r_state == REQ) & w_valid;
   assign s_req_len     = w_len;
   assign s_req_mask    = w_req.mask;
   assign s_req_addr    = w_req.addr;
   assign s_req_we      = w_req.we;
   assign s_req_wrap    = w_req.wrap;
   assign s_write_valid = w_wr & w_wv;
   assign s_write_data  = w_wd;
   assign s_read_ack    = w_rd & w_ack;
   assign m0_req_ready  = (r_state == REQ) & ~r_owner & s_req_ready;
   assign m1_req_ready  = (r_state == REQ) & r_owner & s_req_ready;
   assign m0_read_valid = w_rd & ~r_owner & s_read_valid;
   assign m1_read_valid = w_rd & r_owner & s_read_valid;
   assign m0_read_data  = s_read_data;
   assign m1_read_data  = s_read_data;
   assign owner         = r_owner;

   assign w_acc  = s_req_valid & s_req_ready;
   assign w_beat = r_we ? w_wv : (s_read_valid & w_ack);

   always_comb begin
      w_state_nxt = r_state;
      w_state_nxt = (r_state == IDLE && w_any)                         ? REQ  :
                    (r_state == REQ && w_acc)                          ? DATA :
                    (r_state == DATA && w_beat && r_beats == LW'(1))   ? IDLE : r_state;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_owner <= 1'b0;
         r_we    <= 1'b0;
         r_beats <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && w_any) r_owner <= w_win;
         if (w_acc) begin
            r_beats <= (w_len == '0) ? LW'(1) : w_len;
            r_we    <= w_req.we;
         end else if (r_state == DATA && w_beat) begin
            r_beats <= r_beats - LW'(1);
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven per-cycle vectors plus a hand-written tie sequence;
// honours ARB_RR_EN for the round-robin expectation.
module tb_mem_arbiter;
   logic        clk_i = 1'b0, rst_i;
   logic        m0_req_valid, m0_req_ready, m0_req_we, m0_req_wrap, m0_write_valid;
   logic        m0_read_valid, m0_read_ack;
   logic [2:0]  m0_req_len;
   logic [3:0]  m0_req_mask;
   logic [31:0] m0_req_addr, m0_write_data, m0_read_data;
   logic        m1_req_valid, m1_req_ready, m1_req_we, m1_req_wrap, m1_write_valid;
   logic        m1_read_valid, m1_read_ack;
   logic [2:0]  m1_req_len;
   logic [3:0]  m1_req_mask;
   logic [31:0] m1_req_addr, m1_write_data, m1_read_data;
   logic        s_req_valid, s_req_ready, s_req_we, s_req_wrap, s_write_valid;
   logic        s_read_valid, s_read_ack, owner;
   logic [2:0]  s_req_len;
   logic [3:0]  s_req_mask;
   logic [31:0] s_req_addr, s_write_data, s_read_data;

   int n_chk = 0, n_pass = 0;

   always #5 clk_i = ~clk_i;

   mem_arbiter dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_len(m0_req_len),
      .m0_req_mask(m0_req_mask), .m0_req_addr(m0_req_addr), .m0_req_we(m0_req_we),
      .m0_req_wrap(m0_req_wrap), .m0_write_valid(m0_write_valid), .m0_write_data(m0_write_data),
      .m0_read_valid(m0_read_valid), .m0_read_data(m0_read_data), .m0_read_ack(m0_read_ack),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_len(m1_req_len),
      .m1_req_mask(m1_req_mask), .m1_req_addr(m1_req_addr), .m1_req_we(m1_req_we),
      .m1_req_wrap(m1_req_wrap), .m1_write_valid(m1_write_valid), .m1_write_data(m1_write_data),
      .m1_read_valid(m1_read_valid), .m1_read_data(m1_read_data), .m1_read_ack(m1_read_ack),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_len(s_req_len),
      .s_req_mask(s_req_mask), .s_req_addr(s_req_addr), .s_req_we(s_req_we),
      .s_req_wrap(s_req_wrap), .s_write_valid(s_write_valid), .s_write_data(s_write_data),
      .s_read_valid(s_read_valid), .s_read_data(s_read_data), .s_read_ack(s_read_ack),
      .owner(owner)
   );

   // ex bits: {owner, s_req_valid, m1_rdy, m0_rdy, s_write_valid, m1_rvld, m0_rvld, s_read_ack}
   typedef struct {
      logic        rst;
      logic [1:0]  rv;
      logic        srdy;
      logic [1:0]  wv;
      logic        srv;
      logic [31:0] rd;
      logic [1:0]  ack;
      logic [2:0]  len0;
      logic [7:0]  ex;
      logic [31:0] xd;
   } vec_t;

   function automatic vec_t v(input logic rst, input logic [1:0] rv, input logic srdy,
                              input logic [1:0] wv, input logic srv, input logic [31:0] rd,
                              input logic [1:0] ack, input logic [2:0] len0,
                              input logic [7:0] ex, input logic [31:0] xd);
      vec_t r;
      r.rst = rst; r.rv = rv; r.srdy = srdy; r.wv = wv; r.srv = srv;
      r.rd = rd; r.ack = ack; r.len0 = len0; r.ex = ex; r.xd = xd;
      return r;
   endfunction

   task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s step %0d: got %h want %h", nm, id, got, want);
   endtask

   task automatic step(input int id, input vec_t x);
      logic [7:0] act;
      rst_i = x.rst;
      m0_req_valid = x.rv[0]; m1_req_valid = x.rv[1];
      s_req_ready = x.srdy;
      m0_write_valid = x.wv[0]; m1_write_valid = x.wv[1];
      s_read_valid = x.srv; s_read_data = x.rd;
      m0_read_ack = x.ack[0]; m1_read_ack = x.ack[1];
      m0_req_len = x.len0;
      #2;
      act = {owner, s_req_valid, m1_req_ready, m0_req_ready, s_write_valid,
             m1_read_valid, m0_read_valid, s_read_ack};
      chk("ctl", id, {24'h0, act}, {24'h0, x.ex});
      if (x.ex[6]) chk("addr", id, s_req_addr, x.xd);
      else if (x.ex[3]) chk("wdata", id, s_write_data, x.xd);
      else if (x.ex[2]) chk("m1_rdata", id, m1_read_data, x.xd);
      else if (x.ex[1]) chk("m0_rdata", id, m0_read_data, x.xd);
      @(negedge clk_i);
   endtask

   vec_t tbl[41];

   initial begin
      tbl[0]  = v(0, 2'b00, 0, 2'b00, 0, 32'h0,  2'b00, 3'd4, 8'b0000_0000, 32'h0);
      tbl[1]  = v(0, 2'b01, 0, 2'b00, 0, 32'h0,  2'b00, 3'd4, 8'b0000_0000, 32'h0);
      tbl[2]  = v(0, 2'b01, 1, 2'b00, 0, 32'h0,  2'b00, 3'd4, 8'b0101_0000, 32'h1000);
      tbl[3]  = v(0, 2'b00, 0, 2'b00, 1, 32'hA0, 2'b01, 3'd4, 8'b0000_0011, 32'hA0);
      tbl[4]  = v(0, 2'b00, 0, 2'b00, 1, 32'hA1, 2'b01, 3'd4, 8'b0000_0011, 32'hA1);
      tbl[5]  = v(0, 2'b00, 0, 2'b00, 0, 32'h0,  2'b01, 3'd4, 8'b0000_0001, 32'h0);
      tbl[6]  = v(0, 2'b00, 0, 2'b00, 1, 32'hA2, 2'b01, 3'd4, 8'b0000_0011, 32'hA2);
      tbl[7]  = v(0, 2'b00, 0, 2'b00, 1, 32'hA3, 2'b01, 3'd4, 8'b0000_0011, 32'hA3);
      tbl[8]  = v(0, 2'b00, 0, 2'b00, 1, 32'hFF, 2'b01, 3'd4, 8'b0000_0000, 32'h0);
      tbl[9]  = v(0, 2'b11, 0, 2'b00, 0, 32'h0,  2'b00, 3'd1, 8'b0000_0000, 32'h0);
      tbl[10] = v(0, 2'b11, 1, 2'b00, 0, 32'h0,  2'b00, 3'd1, 8'b0101_0000, 32'h1000);
      tbl[11] = v(0, 2'b10, 0, 2'b00, 1, 32'hB0, 2'b01, 3'd1, 8'b0000_0011, 32'hB0);
      tbl[12] = v(0, 2'b10, 0, 2'b00, 0, 32'h0,  2'b00, 3'd1, 8'b0000_0000, 32'h0);
      tbl[13] = v(0, 2'b10, 1, 2'b00, 0, 32'h0,  2'b00, 3'd1, 8'b1110_0000, 32'h2000);
      tbl[14] = v(0, 2'b00, 0, 2'b11, 0, 32'h0,  2'b00, 3'd1, 8'b1000_1000, 32'hDEADBEEF);
      tbl[15] = v(0, 2'b00, 0, 2'b11, 0, 32'h0,  2'b00, 3'd1, 8'b1000_0000, 32'h0);
      tbl[16] = v(0, 2'b11, 0, 2'b00, 0, 32'h0,  2'b00, 3'd1, 8'b1000_0000, 32'h0);
      tbl[17] = v(0, 2'b11, 0, 2'b01, 0, 32'h0,  2'b00, 3'd1, 8'b0100_0000, 32'h1000);
      tbl[18] = v(0, 2'b11, 0, 2'b00, 0, 32'h0,  2'b00, 3'd1, 8'b0100_0000, 32'h1000);
      tbl[19] = v(0, 2'b10, 0, 2'b00, 0, 32'h0,  2'b00, 3'd1, 8'b0000_0000, 32'h0);
      tbl[20] = v(0, 2'b11, 0, 2'b00, 0, 32'h0,  2'b00, 3'd1, 8'b0100_0000, 32'h1000);
      tbl[21] = v(0, 2'b11, 0, 2'b00, 0, 32'h0,  2'b00, 3'd1, 8'b0100_0000, 32'h1000);
      tbl[22] = v(0, 2'b11, 1, 2'b00, 0, 32'h0,  2'b00, 3'd1, 8'b0101_0000, 32'h1000);
      tbl[23] = v(0, 2'b10, 0, 2'b00, 1, 32'hC0, 2'b01, 3'd1, 8'b0000_0011, 32'hC0);
      tbl[24] = v(0, 2'b10, 0, 2'b00, 0, 32'h0,  2'b00, 3'd1, 8'b0000_0000, 32'h0);
      tbl[25] = v(0, 2'b10, 1, 2'b00, 0, 32'h0,  2'b00, 3'd1, 8'b1110_0000, 32'h2000);
      tbl[26] = v(0, 2'b00, 0, 2'b10, 0, 32'h0,  2'b00, 3'd1, 8'b1000_1000, 32'hDEADBEEF);
      tbl[27] = v(0, 2'b01, 0, 2'b00, 0, 32'h0,  2'b00, 3'd0, 8'b1000_0000, 32'h0);
      tbl[28] = v(0, 2'b01, 1, 2'b00, 0, 32'h0,  2'b00, 3'd0, 8'b0101_0000, 32'h1000);
      tbl[29] = v(0, 2'b00, 0, 2'b00, 1, 32'hD0, 2'b01, 3'd0, 8'b0000_0011, 32'hD0);
      tbl[30] = v(0, 2'b00, 0, 2'b00, 1, 32'hD1, 2'b01, 3'd0, 8'b0000_0000, 32'h0);
      tbl[31] = v(0, 2'b01, 0, 2'b00, 0, 32'h0,  2'b00, 3'd4, 8'b0000_0000, 32'h0);
      tbl[32] = v(0, 2'b01, 1, 2'b00, 0, 32'h0,  2'b00, 3'd4, 8'b0101_0000, 32'h1000);
      tbl[33] = v(0, 2'b00, 0, 2'b00, 1, 32'hE0, 2'b01, 3'd4, 8'b0000_0011, 32'hE0);
      tbl[34] = v(0, 2'b00, 0, 2'b00, 1, 32'hE1, 2'b01, 3'd4, 8'b0000_0011, 32'hE1);
      tbl[35] = v(1, 2'b00, 0, 2'b00, 1, 32'hE2, 2'b01, 3'd4, 8'b0000_0011, 32'hE2);
      tbl[36] = v(0, 2'b00, 0, 2'b01, 1, 32'hE3, 2'b01, 3'd4, 8'b0000_0000, 32'h0);
      tbl[37] = v(0, 2'b10, 0, 2'b00, 0, 32'h0,  2'b00, 3'd4, 8'b0000_0000, 32'h0);
      tbl[38] = v(0, 2'b10, 1, 2'b00, 0, 32'h0,  2'b00, 3'd4, 8'b1110_0000, 32'h2000);
      tbl[39] = v(0, 2'b00, 0, 2'b10, 0, 32'h0,  2'b00, 3'd4, 8'b1000_1000, 32'hDEADBEEF);
      tbl[40] = v(0, 2'b00, 0, 2'b00, 0, 32'h0,  2'b00, 3'd4, 8'b1000_0000, 32'h0);

      rst_i = 1'b1;
      m0_req_valid = 0; m0_req_len = 3'd4; m0_req_mask = 4'hF; m0_req_addr = 32'h1000;
      m0_req_we = 0; m0_req_wrap = 0; m0_write_valid = 0; m0_write_data = 32'h1111_1111;
      m0_read_ack = 0;
      m1_req_valid = 0; m1_req_len = 3'd1; m1_req_mask = 4'b0011; m1_req_addr = 32'h2000;
      m1_req_we = 1; m1_req_wrap = 1; m1_write_valid = 0; m1_write_data = 32'hDEADBEEF;
      m1_read_ack = 0;
      s_req_ready = 0; s_read_valid = 0; s_read_data = 0;
      @(negedge clk_i);
      @(negedge clk_i);

      for (int i = 0; i < 41; i++) step(i, tbl[i]);

      // Tie right after an m0-only grant: round-robin must now favour m1.
      step(100, v(0, 2'b01, 0, 2'b00, 0, 32'h0,  2'b00, 3'd1, 8'b1000_0000, 32'h0));
      step(101, v(0, 2'b01, 1, 2'b00, 0, 32'h0,  2'b00, 3'd1, 8'b0101_0000, 32'h1000));
      step(102, v(0, 2'b00, 0, 2'b00, 1, 32'hF0, 2'b01, 3'd1, 8'b0000_0011, 32'hF0));
      step(103, v(0, 2'b11, 0, 2'b00, 0, 32'h0,  2'b00, 3'd1, 8'b0000_0000, 32'h0));
`ifdef ARB_RR_EN
      step(104, v(0, 2'b11, 0, 2'b00, 0, 32'h0,  2'b00, 3'd1, 8'b1100_0000, 32'h2000));
      chk("rr_mask", 104, {28'h0, s_req_mask}, 32'h3);
      chk("rr_we", 104, {31'h0, s_req_we}, 32'h1);
`else
      step(104, v(0, 2'b11, 0, 2'b00, 0, 32'h0,  2'b00, 3'd1, 8'b0100_0000, 32'h1000));
      chk("fp_mask", 104, {28'h0, s_req_mask}, 32'hF);
      chk("fp_we", 104, {31'h0, s_req_we}, 32'h0);
`endif
      chk("len", 104, {29'h0, s_req_len}, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
